process_scheduler: RTL
======================

// Module: process_scheduler
// PURPOSE
//  Parametrised PC/context unit for the multi-process CPU. Owns the PC register and a
//  per-process table (saved PC + state) for NPROC user processes, plus the OS context (pid 0).
//  Round-robin with quantum preemption; IO traps block; process end retires. Replaces
//  fixed-address PC overrides and PC-range process decoding with explicit pid tracking.
// PARAMETERS
//  PC_W      32   PC / saved-PC width
//  NPROC     10   user processes (pids 1..NPROC); pid 0 = OS
//  QUANTUM   16   retired instructions per slice (>=1)
//  OS_PC     73   OS entry after quantum expiry or dispatch with nothing ready
//  IO_PC     92   OS entry after io_trap
//  END_PC    233  OS entry after proc_end
// PORTS
//  clk          in   1          clock
//  reset        in   1          async, active-high
//  step         in   1          one instruction retires this cycle (0 while halted)
//  pc_next      in   PC_W       datapath next PC (seq/branch/jump)
//  launch       in   1          OS creates process launch_pid at launch_pc
//  launch_pid   in   PID_W      1..NPROC
//  launch_pc    in   PC_W       start PC
//  dispatch     in   1          OS yields CPU to scheduler
//  proc_end     in   1          running user process terminates
//  io_trap      in   1          running user process issues IN/OUT; it blocks
//  io_done      in   1          OS finished IO for io_pid; process becomes READY
//  pc           out  PC_W       current PC
//  pid          out  PID_W      running pid (0 = OS)
//  io_pid       out  PID_W      pid of last trapped process
//  ctx_switch   out  1          high during SEL cycle
//  ready_mask   out  NPROC      bit i-1 = pid i READY
//  quantum_left out  Q_W        remaining slice count
// BEHAVIOUR
//  PID_W=$clog2(NPROC+1), Q_W=$clog2(QUANTUM+1). Reset: pc=0, pid=0, io_pid=0, all FREE,
//   ready_mask=0, quantum_left=QUANTUM, ctx_switch=0, FSM=OS. Reset mid-operation drops all state.
//  Table state per pid: FREE, READY, BLOCKED. The running pid is READY in the table.
//  FSM OS: step -> pc<=pc_next. launch (any state) with pid in range and FREE -> saved_pc<=launch_pc,
//   READY; otherwise ignored. dispatch -> SEL (pc held).
//  FSM RUN: step -> pc<=pc_next, quantum_left-=1. Priority, evaluated only when step=1:
//   proc_end > io_trap > expiry (quantum_left==1).
//   proc_end: pid->FREE, pc<=END_PC, pid<=0, ->OS.
//   io_trap: saved_pc[pid]<=pc_next, ->BLOCKED, io_pid<=pid, pc<=IO_PC, pid<=0, ->OS.
//   expiry: saved_pc[pid]<=pc_next, ->SEL.
//   step=0 freezes pc, quantum_left and all events.
//  FSM SEL (one cycle, ctx_switch=1): search pids cur+1..NPROC,1..cur (cur=pid; from OS cur=0)
//   for first READY -> pid<=it, pc<=saved_pc, quantum_left<=QUANTUM, ->RUN. None READY ->
//   pid<=0, pc<=OS_PC, ->OS. After expiry with only self READY, self is reselected.
//  io_done: io_pid BLOCKED -> READY in any state; otherwise ignored. launch+io_done same cycle
//   on same pid: launch ignored (not FREE). A table write and SEL read of the same pid in
//   the same cycle: SEL sees the pre-write value.
//  Latency: quantum expiry to first instruction of next process = 2 clk.
// STRUCTURE
//  Shared package: state encodings (OS/RUN/SEL; FREE/READY/BLOCKED), OS entry address
//   defaults. Sub-module rr_arbiter (NPROC-wide ready mask + start index -> grant, valid),
//   combinational. Saved-PC table is a register array (NPROC x PC_W).
// TESTING
//  1 reset: pc=0, pid=0, ready_mask=0; 5 steps with pc_next=pc+1 -> pc=5.
//  2 QUANTUM=4: launch pid1@300, pid2@600, dispatch -> pid1 pc=300; after 4 steps
//    ctx_switch=1 for 1 cycle, then pid2 pc=600; after 4 more steps pid1 resumes at 304.
//  3 pid1 io_trap at pc=310 -> pid=0, pc=92, io_pid=1, ready_mask[0]=0; io_done -> bit set;
//    dispatch -> pid1 resumes at 311.
//  4 sole process: proc_end with io_trap same cycle -> pc=233, pid=0, FREE;
//    dispatch -> SEL then pc=73.
//  5 step=0 for 10 cycles in RUN -> pc, quantum_left unchanged; expiry not taken.
//  6 reset mid-RUN -> state of test 1; relaunch on pid previously READY accepted.

Source files
------------

// File: rtl/process_scheduler_pkg.sv
// Shared definitions for the process scheduler slice.
// Holds the scheduler FSM encoding, the per-process table state encoding and
// the default OS entry addresses used by the top level.
package process_scheduler_pkg;

  // Scheduler FSM: OS context running, user process running, one-cycle select
  typedef enum logic [1:0] {
    S_OS  = 2'd0,
    S_RUN = 2'd1,
    S_SEL = 2'd2
  } fsm_t;

  // Per-process table state; the running process stays READY in the table
  typedef enum logic [1:0] {
    P_FREE    = 2'd0,
    P_READY   = 2'd1,
    P_BLOCKED = 2'd2
  } pstate_t;

  // Default OS entry points
  localparam int unsigned OS_PC_DEF  = 73;
  localparam int unsigned IO_PC_DEF  = 92;
  localparam int unsigned END_PC_DEF = 233;

endpackage

// File: rtl/process_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches pids start+1..NPROC first, then 1..start, and grants the first
// requesting pid. With start=0 the search is simply 1..NPROC.
// Ports:
//   req   in  NPROC   bit i-1 = pid i requesting (READY)
//   start in  PID_W   current pid (0 = OS)
//   grant out PID_W   selected pid (0 when nothing requests)
//   valid out 1       a pid was selected
module rr_arbiter #(
  parameter int NPROC = 10,
  parameter int PID_W = $clog2(NPROC + 1)
) (
  input  logic [NPROC-1:0] req,
  input  logic [PID_W-1:0] start,
  output logic [PID_W-1:0] grant,
  output logic             valid
);

  // Two passes with constant indices: pids above start first, then the
  // wrap-around pass over pids up to and including start.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int p = 1; p <= NPROC; p++) begin
      if (!valid && req[p-1] && (PID_W'(p) > start)) begin
        grant = PID_W'(p);
        valid = 1'b1;
      end
    end
    for (int p = 1; p <= NPROC; p++) begin
      if (!valid && req[p-1] && (PID_W'(p) <= start)) begin
        grant = PID_W'(p);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/process_scheduler.sv
// PC / context unit for the multi-process CPU.
// Owns the PC register and a per-process table (saved PC + state) for NPROC
// user processes plus the OS context (pid 0). Round-robin scheduling with
// quantum preemption; IO traps block the caller; process end frees its slot.
// Ports:
//   clk, reset        clock, async active-high reset
//   step              one instruction retires this cycle
//   pc_next           datapath next PC
//   launch/launch_pid/launch_pc   OS creates a process
//   dispatch          OS yields CPU to the scheduler
//   proc_end          running process terminates
//   io_trap           running process blocks on IO
//   io_done           IO finished for io_pid
//   pc, pid, io_pid   current PC, running pid, last trapped pid
//   ctx_switch        high during the select cycle
//   ready_mask        bit i-1 = pid i READY
//   quantum_left      remaining slice count
module process_scheduler
  import process_scheduler_pkg::*;
#(
  parameter int          PC_W    = 32,
  parameter int          NPROC   = 10,
  parameter int          QUANTUM = 16,
  parameter int unsigned OS_PC   = OS_PC_DEF,
  parameter int unsigned IO_PC   = IO_PC_DEF,
  parameter int unsigned END_PC  = END_PC_DEF,
  localparam int         PID_W   = $clog2(NPROC + 1),
  localparam int         Q_W     = $clog2(QUANTUM + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic [PC_W-1:0]  pc_next,
  input  logic             launch,
  input  logic [PID_W-1:0] launch_pid,
  input  logic [PC_W-1:0]  launch_pc,
  input  logic             dispatch,
  input  logic             proc_end,
  input  logic             io_trap,
  input  logic             io_done,
  output logic [PC_W-1:0]  pc,
  output logic [PID_W-1:0] pid,
  output logic [PID_W-1:0] io_pid,
  output logic             ctx_switch,
  output logic [NPROC-1:0] ready_mask,
  output logic [Q_W-1:0]   quantum_left
);

  fsm_t             state, state_n;
  logic [PC_W-1:0]  pc_n;
  logic [PID_W-1:0] pid_n, io_pid_n;
  logic [Q_W-1:0]   quantum_n;
  pstate_t          ptab   [1:NPROC];
  pstate_t          ptab_n [1:NPROC];
  logic [PC_W-1:0]  saved   [1:NPROC];
  logic [PC_W-1:0]  saved_n [1:NPROC];
  logic             do_end, do_trap, do_expire;
  logic [PC_W-1:0]  sel_pc;
  logic [PID_W-1:0] grant;
  logic             grant_valid;

  // The arbiter reads registered table state, so a same-cycle table write
  // is invisible to the select cycle.
  rr_arbiter #(.NPROC(NPROC), .PID_W(PID_W)) u_arb (
    .req   (ready_mask),
    .start (pid),
    .grant (grant),
    .valid (grant_valid)
  );

  assign ctx_switch = (state == S_SEL);

  always_comb begin
    ready_mask = '0;
    for (int i = 1; i <= NPROC; i++) ready_mask[i-1] = (ptab[i] == P_READY);
  end

  always_comb begin
    sel_pc = '0;
    for (int i = 1; i <= NPROC; i++) if (grant == PID_W'(i)) sel_pc = saved[i];
  end

  // Next-state logic: FSM transitions first, then table updates. Updates for
  // the running pid come last; they can never collide with launch (running
  // pid is READY, not FREE) or io_done (io_pid is BLOCKED, not running).
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    pid_n     = pid;
    io_pid_n  = io_pid;
    quantum_n = quantum_left;
    do_end    = 1'b0;
    do_trap   = 1'b0;
    do_expire = 1'b0;

    case (state)
      S_OS: begin
        if (step) pc_n = pc_next;
        if (dispatch) state_n = S_SEL;
      end
      S_RUN: begin
        if (step) begin
          pc_n      = pc_next;
          quantum_n = quantum_left - 1'b1;
          if (proc_end) begin
            do_end  = 1'b1;
            pc_n    = PC_W'(END_PC);
            pid_n   = '0;
            state_n = S_OS;
          end else if (io_trap) begin
            do_trap  = 1'b1;
            io_pid_n = pid;
            pc_n     = PC_W'(IO_PC);
            pid_n    = '0;
            state_n  = S_OS;
          end else if (quantum_left == Q_W'(1)) begin
            do_expire = 1'b1;
            state_n   = S_SEL;
          end
        end
      end
      S_SEL: begin
        if (grant_valid) begin
          pid_n     = grant;
          pc_n      = sel_pc;
          quantum_n = Q_W'(QUANTUM);
          state_n   = S_RUN;
        end else begin
          pid_n   = '0;
          pc_n    = PC_W'(OS_PC);
          state_n = S_OS;
        end
      end
      default: state_n = S_OS;
    endcase

    for (int i = 1; i <= NPROC; i++) begin
      ptab_n[i]  = ptab[i];
      saved_n[i] = saved[i];
      if (io_done && (io_pid == PID_W'(i)) && (ptab[i] == P_BLOCKED)) ptab_n[i] = P_READY;
      if (launch && (launch_pid == PID_W'(i)) && (ptab[i] == P_FREE)) begin
        saved_n[i] = launch_pc;
        ptab_n[i]  = P_READY;
      end
      if (pid == PID_W'(i)) begin
        if (do_end) ptab_n[i] = P_FREE;
        if (do_trap) begin
          saved_n[i] = pc_next;
          ptab_n[i]  = P_BLOCKED;
        end
        if (do_expire) saved_n[i] = pc_next;
      end
    end
  end

  // State registers; reset drops all process state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_OS;
      pc           <= '0;
      pid          <= '0;
      io_pid       <= '0;
      quantum_left <= Q_W'(QUANTUM);
      for (int i = 1; i <= NPROC; i++) begin
        ptab[i]  <= P_FREE;
        saved[i] <= '0;
      end
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      pid          <= pid_n;
      io_pid       <= io_pid_n;
      quantum_left <= quantum_n;
      for (int i = 1; i <= NPROC; i++) begin
        ptab[i]  <= ptab_n[i];
        saved[i] <= saved_n[i];
      end
    end
  end

endmodule
